// File: rtl/varlat_interco_pkg.sv
// Shared helpers for the in-order variable-latency crossbar: index widths for
// initiator/bank identifiers carried in the tracking FIFOs.
package varlat_interco_pkg;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned bank_width(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small non-fall-through FIFO with the fifo_v3 port naming; head is valid
// only from the cycle after the push that filled an empty FIFO.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]       r_wptr;
    logic [PtrW-1:0]       r_rptr;
    logic [CntW-1:0]       r_cnt;
    logic                  w_push;
    logic                  w_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (r_cnt == CntW'(DEPTH));
    assign empty_o = (r_cnt == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign data_o  = r_mem[r_rptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            if (w_push && !w_pop)      r_cnt <= r_cnt + CntW'(1);
            else if (w_pop && !w_push) r_cnt <= r_cnt - CntW'(1);
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= data_i;
    end

endmodule

// File: rtl/varlat_rr_arb.sv
// Round-robin arbiter for one bank; the priority pointer only advances when
// the bank actually accepts the winning request.
module varlat_rr_arb #(
    parameter int unsigned NumIn = 4,
    parameter int unsigned IdxW  = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NumIn-1:0] req_i,
    input  logic             hs_i,
    output logic [NumIn-1:0] gnt_o,
    output logic [IdxW-1:0]  idx_o,
    output logic             req_o
);
    logic [IdxW-1:0] r_ptr;
    logic            w_found;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        w_found = 1'b0;
        // First pass: requesters at or above the pointer; second pass wraps.
        for (int j = 0; j < NumIn; j++) begin
            if (!w_found && req_i[j] && (IdxW'(j) >= r_ptr)) begin
                w_found  = 1'b1;
                idx_o    = IdxW'(j);
                gnt_o[j] = 1'b1;
            end
        end
        for (int j = 0; j < NumIn; j++) begin
            if (!w_found && req_i[j]) begin
                w_found  = 1'b1;
                idx_o    = IdxW'(j);
                gnt_o[j] = 1'b1;
            end
        end
    end

    assign req_o = |req_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (hs_i) begin
            r_ptr <= (idx_o == IdxW'(NumIn - 1)) ? '0 : idx_o + IdxW'(1);
        end
    end

endmodule

// File: rtl/varlat_inorder_xbar.sv
// NumIn x NumOut crossbar to variable-latency banks; per-initiator and per-bank
// tracking FIFOs keep each initiator's responses in request order across banks.
module varlat_inorder_xbar
    import varlat_interco_pkg::*;
#(
    parameter int unsigned NumIn          = 4,
    parameter int unsigned NumOut         = 8,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned BeWidth        = DataWidth / 8,
    parameter int unsigned AddrMemWidth   = 12,
    parameter int unsigned ByteOffWidth   = $clog2(DataWidth - 1) - 3,
    parameter int unsigned NumOutstanding = 2,
    parameter int unsigned WriteRespOn    = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumIn-1:0]               req_i,
    input  logic [NumIn*AddrWidth-1:0]     add_i,
    input  logic [NumIn-1:0]               we_i,
    input  logic [NumIn*DataWidth-1:0]     wdata_i,
    input  logic [NumIn*BeWidth-1:0]       be_i,
    output logic [NumIn-1:0]               gnt_o,
    output logic [NumIn-1:0]               vld_o,
    output logic [NumIn*DataWidth-1:0]     rdata_o,
    output logic                           idle_o,
    output logic [NumOut-1:0]              req_o,
    input  logic [NumOut-1:0]              gnt_i,
    output logic [NumOut*AddrMemWidth-1:0] add_o,
    output logic [NumOut-1:0]              we_o,
    output logic [NumOut*DataWidth-1:0]    wdata_o,
    output logic [NumOut*BeWidth-1:0]      be_o,
    input  logic [NumOut-1:0]              rvalid_i,
    output logic [NumOut-1:0]              rready_o,
    input  logic [NumOut*DataWidth-1:0]    rdata_i
);
    localparam int unsigned BankW = bank_width(NumOut);
    localparam int unsigned IniW  = idx_width(NumIn);

    typedef struct packed {
        logic                    we;
        logic [BeWidth-1:0]      be;
        logic [AddrMemWidth-1:0] addr;
        logic [DataWidth-1:0]    wdata;
    } agg_req_t;

    agg_req_t         w_ini_req  [NumIn];
    logic [BankW-1:0] w_bank_sel [NumIn];
    logic [BankW-1:0] w_ini_head [NumIn];
    logic [NumIn-1:0] w_tracked, w_ini_full, w_ini_empty, w_ini_push, w_ini_pop;

    logic [IniW-1:0]   w_bank_head [NumOut];
    logic [IniW-1:0]   w_win_idx   [NumOut];
    logic [NumIn-1:0]  w_elig      [NumOut];
    logic [NumIn-1:0]  w_win       [NumOut];
    logic [NumOut-1:0] w_bank_full, w_bank_empty, w_bank_push, w_bank_pop, w_hs;
    logic              w_unused_addr;

    assign w_unused_addr = ^add_i;

    always_comb begin
        for (int i = 0; i < NumIn; i++) begin
            w_bank_sel[i]      = add_i[i*AddrWidth + ByteOffWidth +: BankW];
            w_ini_req[i].addr  = add_i[i*AddrWidth + ByteOffWidth + BankW +: AddrMemWidth];
            w_ini_req[i].we    = we_i[i];
            w_ini_req[i].be    = be_i[i*BeWidth +: BeWidth];
            w_ini_req[i].wdata = wdata_i[i*DataWidth +: DataWidth];
            w_tracked[i]       = ~we_i[i] | (WriteRespOn != 0);
        end
    end

    // A full tracking FIFO blocks a tracked request even if it pops this cycle.
    always_comb begin
        for (int k = 0; k < NumOut; k++) begin
            w_elig[k] = '0;
            for (int i = 0; i < NumIn; i++) begin
                w_elig[k][i] = req_i[i] && (w_bank_sel[i] == BankW'(k)) &&
                               (!w_tracked[i] || (!w_ini_full[i] && !w_bank_full[k]));
            end
        end
    end

    for (genvar k = 0; k < NumOut; k++) begin : g_bank
        varlat_rr_arb #(.NumIn(NumIn), .IdxW(IniW)) u_arb (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .req_i  (w_elig[k]),
            .hs_i   (w_hs[k]),
            .gnt_o  (w_win[k]),
            .idx_o  (w_win_idx[k]),
            .req_o  (req_o[k])
        );

        assign w_hs[k]        = req_o[k] & gnt_i[k];
        assign w_bank_push[k] = w_hs[k] & w_tracked[w_win_idx[k]];

        fifo_v3 #(.DATA_WIDTH(IniW), .DEPTH(NumOutstanding)) u_bank_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .full_o  (w_bank_full[k]),
            .empty_o (w_bank_empty[k]),
            .data_i  (w_win_idx[k]),
            .push_i  (w_bank_push[k]),
            .data_o  (w_bank_head[k]),
            .pop_i   (w_bank_pop[k])
        );

        assign add_o[k*AddrMemWidth +: AddrMemWidth] = w_ini_req[w_win_idx[k]].addr;
        assign we_o[k]                               = w_ini_req[w_win_idx[k]].we;
        assign be_o[k*BeWidth +: BeWidth]            = w_ini_req[w_win_idx[k]].be;
        assign wdata_o[k*DataWidth +: DataWidth]     = w_ini_req[w_win_idx[k]].wdata;

        // Accept only when this bank is next in line for its head initiator.
        assign rready_o[k]   = !w_bank_empty[k] && !w_ini_empty[w_bank_head[k]] &&
                               (w_ini_head[w_bank_head[k]] == BankW'(k));
        assign w_bank_pop[k] = rvalid_i[k] & rready_o[k];

        a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(rvalid_i[k] && w_bank_empty[k]));
    end

    for (genvar i = 0; i < NumIn; i++) begin : g_ini
        fifo_v3 #(.DATA_WIDTH(BankW), .DEPTH(NumOutstanding)) u_ini_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .full_o  (w_ini_full[i]),
            .empty_o (w_ini_empty[i]),
            .data_i  (w_bank_sel[i]),
            .push_i  (w_ini_push[i]),
            .data_o  (w_ini_head[i]),
            .pop_i   (w_ini_pop[i])
        );

        assign gnt_o[i]      = w_win[w_bank_sel[i]][i] & gnt_i[w_bank_sel[i]];
        assign w_ini_push[i] = gnt_o[i] & w_tracked[i];
        assign vld_o[i]      = !w_ini_empty[i] && rvalid_i[w_ini_head[i]] &&
                               rready_o[w_ini_head[i]] &&
                               (w_bank_head[w_ini_head[i]] == IniW'(i));
        assign w_ini_pop[i]  = vld_o[i];
        assign rdata_o[i*DataWidth +: DataWidth] =
            rdata_i[32'(w_ini_head[i])*DataWidth +: DataWidth];
    end

    assign idle_o = &w_ini_empty;

endmodule

// File: tb/tb_varlat_inorder_xbar.sv
// Directed bench for varlat_inorder_xbar: a decode/arbitration vector table
// followed by hand-written multi-cycle response-ordering sequences.
module tb_varlat_inorder_xbar;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req_i, we_i, gnt_o, vld_o;
    logic [127:0]  add_i, wdata_i, rdata_o;
    logic [15:0]   be_i;
    logic          idle_o;
    logic [7:0]    req_o, gnt_i, we_o, rvalid_i, rready_o;
    logic [95:0]   add_o;
    logic [255:0]  wdata_o, rdata_i;
    logic [31:0]   be_o;

    logic [3:0]    b_req, b_we, b_gnt, b_vld;
    logic [127:0]  b_add, b_unused_rdata;
    logic          b_idle;
    logic [7:0]    b_unused_req_o, b_gnt_i, b_we_o, b_rvalid, b_unused_rready;
    logic [95:0]   b_unused_add_o;
    logic [255:0]  b_unused_wdata_o;
    logic [31:0]   b_unused_be_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    varlat_inorder_xbar u_dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .add_i(add_i), .we_i(we_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .vld_o(vld_o), .rdata_o(rdata_o),
        .idle_o(idle_o), .req_o(req_o), .gnt_i(gnt_i), .add_o(add_o), .we_o(we_o),
        .wdata_o(wdata_o), .be_o(be_o), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .rdata_i(rdata_i)
    );

    varlat_inorder_xbar #(.WriteRespOn(0)) u_dut_nowr (
        .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .add_i(b_add), .we_i(b_we),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(b_gnt), .vld_o(b_vld), .rdata_o(b_unused_rdata),
        .idle_o(b_idle), .req_o(b_unused_req_o), .gnt_i(b_gnt_i), .add_o(b_unused_add_o),
        .we_o(b_we_o), .wdata_o(b_unused_wdata_o), .be_o(b_unused_be_o), .rvalid_i(b_rvalid),
        .rready_o(b_unused_rready), .rdata_i(rdata_i)
    );

    typedef struct packed {
        logic [3:0]   req;
        logic [127:0] add;
        logic [7:0]   gnt_i;
        logic [3:0]   exp_gnt;
        logic [7:0]   exp_req_o;
        logic [2:0]   bank;
        logic [11:0]  exp_addr;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int out, gcnt, vcnt, idle_min;
        logic hs, pp;

        vecs[0] = '{req: 4'b0001, add: {32'h0, 32'h0, 32'h0, 32'h24C}, gnt_i: 8'hFF,
                    exp_gnt: 4'b0001, exp_req_o: 8'h08, bank: 3'd3, exp_addr: 12'h012};
        vecs[1] = '{req: 4'b1111, add: {32'h68, 32'h48, 32'h28, 32'h08}, gnt_i: 8'hFF,
                    exp_gnt: 4'b0001, exp_req_o: 8'h04, bank: 3'd2, exp_addr: 12'h000};
        vecs[2] = '{req: 4'b1111, add: {32'h68, 32'h48, 32'h28, 32'h08}, gnt_i: 8'h00,
                    exp_gnt: 4'b0000, exp_req_o: 8'h04, bank: 3'd2, exp_addr: 12'h000};
        vecs[3] = '{req: 4'b1111, add: {32'h2014, 32'hFFFF_FFFC, 32'hA4, 32'h0}, gnt_i: 8'hA3,
                    exp_gnt: 4'b1111, exp_req_o: 8'hA3, bank: 3'd7, exp_addr: 12'hFFF};
        vecs[4] = '{req: 4'b1111, add: {32'h2014, 32'hFFFF_FFFC, 32'hA4, 32'h0}, gnt_i: 8'h21,
                    exp_gnt: 4'b1001, exp_req_o: 8'hA3, bank: 3'd5, exp_addr: 12'h100};
        vecs[5] = '{req: 4'b0110, add: {32'h0, 32'h138, 32'hF8, 32'h0}, gnt_i: 8'hFF,
                    exp_gnt: 4'b0010, exp_req_o: 8'h40, bank: 3'd6, exp_addr: 12'h007};

        rst_n = 1'b0; req_i = '0; add_i = '0; we_i = '0; wdata_i = '0; be_i = '1;
        gnt_i = '0; rvalid_i = '0; rdata_i = '0;
        b_req = '0; b_add = '0; b_we = '0; b_gnt_i = '0; b_rvalid = '0;
        #1;
        check("rst_gnt", 64'(gnt_o), 0);
        check("rst_vld", 64'(vld_o), 0);
        check("rst_rready", 64'(rready_o), 0);
        check("rst_req_o", 64'(req_o), 0);
        check("rst_idle", 64'(idle_o), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Decode and single-cycle arbitration; requests drop before the edge.
        for (int v = 0; v < 6; v++) begin
            req_i = vecs[v].req; add_i = vecs[v].add; gnt_i = vecs[v].gnt_i;
            #1;
            check($sformatf("tbl%0d_gnt", v), 64'(gnt_o), 64'(vecs[v].exp_gnt));
            check($sformatf("tbl%0d_req_o", v), 64'(req_o), 64'(vecs[v].exp_req_o));
            check($sformatf("tbl%0d_addr", v), 64'(add_o[vecs[v].bank*12 +: 12]),
                  64'(vecs[v].exp_addr));
            req_i = '0;
            step();
        end

        // Single load to bank 3, response five cycles later.
        gnt_i = 8'hFF; add_i = {96'h0, 32'h24C}; req_i = 4'b0001;
        #1 check("s1_gnt", 64'(gnt_o), 1);
        step(); req_i = '0;
        #1 check("s1_busy", 64'(idle_o), 0);
        vcnt = 0;
        for (int c = 1; c < 5; c++) begin
            vcnt += int'(vld_o != 0);
            step();
        end
        check("s1_early_vld", 64'(vcnt), 0);
        rvalid_i[3] = 1'b1; rdata_i[3*32 +: 32] = 32'hA5;
        #1;
        check("s1_rready", 64'(rready_o[3]), 1);
        check("s1_vld", 64'(vld_o), 64'h1);
        check("s1_rdata", 64'(rdata_o[31:0]), 64'hA5);
        step(); rvalid_i[3] = 1'b0;
        #1;
        check("s1_vld_off", 64'(vld_o), 0);
        check("s1_idle", 64'(idle_o), 1);

        // All four initiators load bank 2; bank answers one cycle after each grant.
        req_i = 4'b1111; add_i = {32'h68, 32'h48, 32'h28, 32'h08}; out = 0;
        for (int c = 0; c < 9; c++) begin
            if (c == 8) req_i = '0;
            rvalid_i[2] = (out > 0);
            rdata_i[2*32 +: 32] = 32'hB000_0000 | 32'(c);
            #1;
            if (c < 8) check($sformatf("s2_gnt%0d", c), 64'(gnt_o), 64'(1) << (c % 4));
            if (c > 0) begin
                check($sformatf("s2_vld%0d", c), 64'(vld_o), 64'(1) << ((c - 1) % 4));
                check($sformatf("s2_rdata%0d", c), 64'(rdata_o[((c - 1) % 4)*32 +: 32]),
                      64'(32'hB000_0000 | 32'(c)));
            end
            hs = req_o[2] & gnt_i[2];
            pp = rvalid_i[2] & rready_o[2];
            step();
            out = out + int'(hs) - int'(pp);
        end
        rvalid_i[2] = 1'b0;
        #1 check("s2_idle", 64'(idle_o), 1);

        // Ini1: slow bank 0 then fast bank 1; bank 1 must wait its turn.
        req_i = 4'b0010; add_i = {96'h0, 32'h20, 32'h0};
        #1 check("s3_gnt0", 64'(gnt_o), 64'h2);
        step();
        add_i[63:32] = 32'h24;
        #1 check("s3_gnt1", 64'(gnt_o), 64'h2);
        step(); req_i = '0;
        rvalid_i[1] = 1'b1; rdata_i[1*32 +: 32] = 32'h1111;
        vcnt = 0;
        for (int c = 2; c < 6; c++) begin
            #1 vcnt += int'(rready_o[1]) + int'(vld_o != 0);
            step();
        end
        check("s3_bank1_held", 64'(vcnt), 0);
        rvalid_i[0] = 1'b1; rdata_i[31:0] = 32'hB00;
        #1;
        check("s3_rready_b0", 64'(rready_o[1:0]), 64'h1);
        check("s3_vld_b0", 64'(vld_o), 64'h2);
        check("s3_rdata_b0", 64'(rdata_o[63:32]), 64'hB00);
        step(); rvalid_i[0] = 1'b0;
        #1;
        check("s3_rready_b1", 64'(rready_o[1]), 1);
        check("s3_vld_b1", 64'(vld_o), 64'h2);
        check("s3_rdata_b1", 64'(rdata_o[63:32]), 64'h1111);
        step(); rvalid_i[1] = 1'b0;
        #1 check("s3_idle", 64'(idle_o), 1);

        // Outstanding limit on bank 4 (depth 2), then refill after one response.
        req_i = 4'b0001; add_i = {96'h0, 32'h30};
        #1 check("s4_g0", 64'(gnt_o), 1);
        step();
        #1 check("s4_g1", 64'(gnt_o), 1);
        step();
        #1 check("s4_full", 64'(gnt_o), 0);
        step();
        rvalid_i[4] = 1'b1; rdata_i[4*32 +: 32] = 32'hC3;
        #1;
        check("s4_nobypass", 64'(gnt_o), 0);
        check("s4_vld", 64'(vld_o), 1);
        check("s4_rdata", 64'(rdata_o[31:0]), 64'hC3);
        step(); rvalid_i[4] = 1'b0;
        #1 check("s4_regrant", 64'(gnt_o), 1);
        step(); req_i = '0;

        // Reset with two loads outstanding and a response pending.
        rvalid_i[4] = 1'b1;
        #1 check("s5_pre_rready", 64'(rready_o[4]), 1);
        rst_n = 1'b0;
        #1;
        check("s5_gnt", 64'(gnt_o), 0);
        check("s5_vld", 64'(vld_o), 0);
        check("s5_rready", 64'(rready_o), 0);
        check("s5_idle", 64'(idle_o), 1);
        rvalid_i = '0;
        step();
        rst_n = 1'b1;
        step();
        req_i = 4'b0100; add_i = {32'h0, 32'h34, 64'h0};
        #1 check("s5_post_gnt", 64'(gnt_o), 64'h4);
        step(); req_i = '0;
        #1 check("s5_post_wait", 64'(vld_o), 0);
        step();
        rvalid_i[5] = 1'b1; rdata_i[5*32 +: 32] = 32'h1234_5678;
        #1;
        check("s5_post_vld", 64'(vld_o), 64'h4);
        check("s5_post_rdata", 64'(rdata_o[95:64]), 64'h1234_5678);
        step(); rvalid_i[5] = 1'b0;
        #1 check("s5_post_idle", 64'(idle_o), 1);

        // Untracked stores on the WriteRespOn=0 instance.
        b_req = 4'b0001; b_we = 4'b0001; b_add = {96'h0, 32'h04}; b_gnt_i = 8'hFF;
        vcnt = 0; idle_min = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("s6b_gnt%0d", c), 64'(b_gnt), 1);
            check($sformatf("s6b_we%0d", c), 64'(b_we_o[1]), 1);
            vcnt += int'(b_vld != 0);
            if (!b_idle) idle_min = 0;
            step();
        end
        b_req = '0;
        #1;
        check("s6b_no_vld", 64'(vcnt + int'(b_vld != 0)), 0);
        check("s6b_idle", 64'(idle_min & int'(b_idle)), 1);

        // Tracked stores on the default instance each return a response.
        we_i = 4'b0001; add_i = {96'h0, 32'h18}; wdata_i[31:0] = 32'hDEAD_BEEF;
        out = 0; gcnt = 0; vcnt = 0;
        for (int c = 0; c < 6; c++) begin
            req_i = (c < 3) ? 4'b0001 : 4'b0000;
            rvalid_i[6] = (out > 0);
            #1;
            if (c == 0) begin
                check("s6a_we_o", 64'(we_o[6]), 1);
                check("s6a_wdata_o", 64'(wdata_o[6*32 +: 32]), 64'hDEAD_BEEF);
            end
            gcnt += int'(gnt_o[0]);
            vcnt += int'(vld_o[0]);
            hs = req_o[6] & gnt_i[6];
            pp = rvalid_i[6] & rready_o[6];
            step();
            out = out + int'(hs) - int'(pp);
        end
        rvalid_i[6] = 1'b0;
        #1;
        check("s6a_gnts", 64'(gcnt), 3);
        check("s6a_vlds", 64'(vcnt), 3);
        check("s6a_idle", 64'(idle_o), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
